// File: rtl/ace_aw_snoop_sequencer.sv
// ACE AW snoop sequencer: each accepted AW is dropped, forwarded, or snooped and then forwarded.
// Optional snoop-response timeout is enabled by defining ACE_AW_SEQ_SNOOP_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | ready for the next upstream AW
// ERR        | illegal AW dropped, illegal_o pulses
// SNOOP_REQ  | AC broadcast, waiting until every port has accepted
// SNOOP_RESP | collecting CR from every port
// FWD        | registered AW presented downstream
module ace_aw_snoop_sequencer #(
   parameter int unsigned NumSnoopPorts = 2,
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned AwWidth       = 64,
   parameter type         aw_chan_t     = logic [AwWidth-1:0],
   parameter type         acsnoop_t     = logic [3:0]
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       slv_aw_valid_i,
   output logic                       slv_aw_ready_o,
   input  aw_chan_t                   slv_aw_i,
   input  acsnoop_t                   dec_acsnoop_i,
   input  logic                       dec_snooping_i,
   input  logic                       dec_illegal_i,
   output logic                       mst_aw_valid_o,
   input  logic                       mst_aw_ready_i,
   output aw_chan_t                   mst_aw_o,
   output logic [NumSnoopPorts-1:0]   ac_valid_o,
   input  logic [NumSnoopPorts-1:0]   ac_ready_i,
   output logic [AddrWidth-1:0]       ac_addr_o,
   output acsnoop_t                   ac_snoop_o,
   output logic [2:0]                 ac_prot_o,
   input  logic [NumSnoopPorts-1:0]   cr_valid_i,
   output logic [NumSnoopPorts-1:0]   cr_ready_o,
   input  logic [NumSnoopPorts*5-1:0] cr_resp_i,
   output logic [4:0]                 crresp_or_o,
   output logic                       illegal_o,
   output logic                       timeout_o
);

   typedef enum logic [2:0] {IDLE, ERR, SNOOP_REQ, SNOOP_RESP, FWD} state_t;

   state_t                   state_q, state_d;
   aw_chan_t                 aw_q, aw_d;
   acsnoop_t                 acsnoop_q, acsnoop_d;
   logic [NumSnoopPorts-1:0] ac_done_q, ac_done_d;
   logic [NumSnoopPorts-1:0] cr_done_q, cr_done_d;
   logic [NumSnoopPorts-1:0] cr_hs;
   logic [4:0]               acc_q, acc_d;
   logic [4:0]               crresp_q, crresp_d;
   logic                     timeout_hit;

`ifdef ACE_AW_SEQ_SNOOP_TIMEOUT_EN
   logic [15:0] cnt_q;

   // Held at zero outside SNOOP_RESP, so it reads 0 in the first response cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != SNOOP_RESP) cnt_q <= '0;
      else                                cnt_q <= cnt_q + 16'd1;
   end

   assign timeout_hit = (state_q == SNOOP_RESP) && (cnt_q == 16'(TimeoutCycles));
`else
   assign timeout_hit = 1'b0;
`endif

   assign mst_aw_o    = aw_q;
   assign crresp_or_o = crresp_q;
   assign ac_addr_o   = (state_q == SNOOP_REQ) ? aw_q[AddrWidth-1:0] : '0;
   assign ac_prot_o   = (state_q == SNOOP_REQ) ? aw_q[AddrWidth+2:AddrWidth] : 3'b000;
   assign ac_snoop_o  = (state_q == SNOOP_REQ) ? acsnoop_q : '0;

   always_comb begin
      state_d        = state_q;
      aw_d           = aw_q;
      acsnoop_d      = acsnoop_q;
      ac_done_d      = ac_done_q;
      cr_done_d      = cr_done_q;
      acc_d          = acc_q;
      crresp_d       = crresp_q;
      cr_hs          = '0;
      slv_aw_ready_o = 1'b0;
      mst_aw_valid_o = 1'b0;
      ac_valid_o     = '0;
      cr_ready_o     = '0;
      illegal_o      = 1'b0;
      timeout_o      = 1'b0;
      case (state_q)
         IDLE: begin
            slv_aw_ready_o = 1'b1;
            if (slv_aw_valid_i) begin
               aw_d      = slv_aw_i;
               acsnoop_d = dec_acsnoop_i;
               if (dec_illegal_i) begin
                  state_d = ERR;
               end else if (dec_snooping_i) begin
                  state_d   = SNOOP_REQ;
                  ac_done_d = '0;
                  cr_done_d = '0;
                  acc_d     = '0;
                  crresp_d  = '0;
               end else begin
                  state_d = FWD;
               end
            end
         end
         ERR: begin
            illegal_o = 1'b1;
            state_d   = IDLE;
         end
         SNOOP_REQ: begin
            ac_valid_o = ~ac_done_q;
            ac_done_d  = ac_done_q | (ac_valid_o & ac_ready_i);
            if (&ac_done_d) begin
               state_d   = SNOOP_RESP;
               ac_done_d = '0;
               cr_done_d = '0;
            end
         end
         SNOOP_RESP: begin
            cr_ready_o = ~cr_done_q;
            cr_hs      = cr_valid_i & cr_ready_o;
            cr_done_d  = cr_done_q | cr_hs;
            for (int i = 0; i < int'(NumSnoopPorts); i++) begin
               if (cr_hs[i]) acc_d = acc_d | cr_resp_i[i*5 +: 5];
            end
            // A response completing this cycle takes priority over a timeout.
            if (&cr_done_d) begin
               state_d   = FWD;
               crresp_d  = acc_d;
               cr_done_d = '0;
            end else if (timeout_hit) begin
               timeout_o = 1'b1;
               state_d   = FWD;
               crresp_d  = acc_d;
               cr_done_d = '0;
            end
         end
         FWD: begin
            mst_aw_valid_o = 1'b1;
            if (mst_aw_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         aw_q      <= '0;
         acsnoop_q <= '0;
         ac_done_q <= '0;
         cr_done_q <= '0;
         acc_q     <= '0;
         crresp_q  <= '0;
      end else begin
         state_q   <= state_d;
         aw_q      <= aw_d;
         acsnoop_q <= acsnoop_d;
         ac_done_q <= ac_done_d;
         cr_done_q <= cr_done_d;
         acc_q     <= acc_d;
         crresp_q  <= crresp_d;
      end
   end

endmodule
